// File: rtl/addsub_serial_ctrl_if.sv
// Request/result bundle for the byte-serial add/subtract sequencer.
// The master side issues operands and consumes results; the slave is the sequencer.
interface addsub_serial_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic         o_cout;
  logic         o_ovf;
  logic         o_zero;
  logic         o_busy;

  modport master (
    output i_valid, i_a, i_b, i_sub, i_ready,
    input  o_ready, o_valid, o_result, o_cout, o_ovf, o_zero, o_busy
  );

  modport slave (
    input  i_valid, i_a, i_b, i_sub, i_ready,
    output o_ready, o_valid, o_result, o_cout, o_ovf, o_zero, o_busy
  );
endinterface

// File: rtl/addsub_serial_ctrl.sv
// Byte-serial add/subtract: one 8-bit slice reused NBYTES times, LSB first,
// with valid/ready on both sides and carry/borrow, overflow and zero flags.
module addsub_serial_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  addsub_serial_ctrl_if.slave  bus
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           carry_reg, carry_next;
  logic           sub_reg, sub_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [W-1:0]   result_reg, result_next;
  logic           cout_reg, cout_next;
  logic           ovf_reg, ovf_next;
  logic           zero_reg, zero_next;

  logic [7:0]     a_lane [NBYTES];
  logic [7:0]     b_lane [NBYTES];
  logic [7:0]     a_byte;
  logic [7:0]     b_inv;
  logic [8:0]     slice_sum;
  logic           calc_en;

  assign calc_en = (state_reg == CALC);

  // Byte lanes of the operands, and the result lane written by the slice this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign a_lane[gi] = a_reg[gi*8 +: 8];
      assign b_lane[gi] = b_reg[gi*8 +: 8];
      assign result_next[gi*8 +: 8] = (calc_en && (cnt_reg == CW'(gi)))
                                      ? slice_sum[7:0]
                                      : result_reg[gi*8 +: 8];
    end
  endgenerate

  // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
  assign a_byte    = a_lane[cnt_reg];
  assign b_inv     = b_lane[cnt_reg] ^ {8{sub_reg}};
  assign slice_sum = {1'b0, a_byte} + {1'b0, b_inv} + {8'd0, carry_reg};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      sub_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      carry_reg  <= carry_next;
      sub_reg    <= sub_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      cout_reg   <= cout_next;
      ovf_reg    <= ovf_next;
      zero_reg   <= zero_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    sub_next   = sub_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    zero_next  = zero_reg;

    case (state_reg)
      IDLE: begin
        if (bus.i_valid) begin
          a_next     = bus.i_a;
          b_next     = bus.i_b;
          sub_next   = bus.i_sub;
          carry_next = bus.i_sub;
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        carry_next = slice_sum[8];
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == LAST_BYTE) begin
          cnt_next   = '0;
          state_next = DONE;
          // Raw carry becomes borrow when subtracting.
          cout_next  = slice_sum[8] ^ sub_reg;
          ovf_next   = (a_byte[7] == b_inv[7]) && (slice_sum[7] != a_byte[7]);
          // Lower bytes already hold this operation's result by the final edge.
          zero_next  = ~(|result_reg[W-9:0]) & ~(|slice_sum[7:0]);
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.o_ready  = (state_reg == IDLE);
  assign bus.o_valid  = (state_reg == DONE);
  assign bus.o_busy   = (state_reg != IDLE);
  assign bus.o_result = result_reg;
  assign bus.o_cout   = cout_reg;
  assign bus.o_ovf    = ovf_reg;
  assign bus.o_zero   = zero_reg;

  a_done_holds: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_reg == DONE && !bus.i_ready) |=> (state_reg == DONE));

  a_calc_finishes: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_reg == CALC && cnt_reg == LAST_BYTE) |=> (state_reg == DONE));

endmodule
